// File: rtl/cp0_regfile_ctrl_if.sv
// Pipeline-facing bundle of the CP0 register file: ID decode/write, MEM exception commit, status outputs.
interface cp0_regfile_ctrl_if #(
  parameter int NUM_HW_INT = 6
);
  logic                  stall;
  logic [31:0]           inst;
  logic [31:0]           reg_data_1;
  logic [NUM_HW_INT-1:0] int_in;
  logic                  exc_valid;
  logic [4:0]            exc_code;
  logic [31:0]           exc_epc;
  logic                  exc_bd;
  logic [31:0]           exc_badvaddr;
  logic [31:0]           cp0_read_data;
  logic                  cp0_read_valid;
  logic                  illegal;
  logic                  int_pending;
  logic                  eret;
  logic [31:0]           epc_out;
  logic [31:0]           status_out;
  logic [31:0]           cause_out;

  modport master (
    output stall, inst, reg_data_1, int_in, exc_valid, exc_code, exc_epc, exc_bd, exc_badvaddr,
    input  cp0_read_data, cp0_read_valid, illegal, int_pending, eret, epc_out, status_out, cause_out
  );

  modport slave (
    input  stall, inst, reg_data_1, int_in, exc_valid, exc_code, exc_epc, exc_bd, exc_badvaddr,
    output cp0_read_data, cp0_read_valid, illegal, int_pending, eret, epc_out, status_out, cause_out
  );
endinterface

// File: rtl/cp0_regfile_ctrl.sv
// CP0 register file and MTC0/MFC0/ERET decoder with exception entry/return sequencing.
// Optional Count/Compare timer is compiled in when CP0_TIMER_EN is defined.
module cp0_regfile_ctrl #(
  parameter int          NUM_HW_INT   = 6,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input logic clk,
  input logic rst,
  cp0_regfile_ctrl_if.slave bus
);

  localparam logic [7:0] A_BADV    = {5'd8, 3'd0};
  localparam logic [7:0] A_COUNT   = {5'd9, 3'd0};
  localparam logic [7:0] A_COMPARE = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS  = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE   = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC     = {5'd14, 3'd0};

`ifdef CP0_TIMER_EN
  localparam int HW_W = 5;
`else
  localparam int HW_W = 6;
`endif

  if (NUM_HW_INT < 1 || NUM_HW_INT > HW_W || COUNT_DIV < 1) begin : g_bad_param
    $error("cp0_regfile_ctrl: NUM_HW_INT or COUNT_DIV out of range");
  end

  logic       op_cp0, is_mtc0, is_mfc0, is_eret;
  logic       mtc0_fire, mfc0_fire, eret_fire;
  logic [7:0] addr;
  logic [31:0] wdata;

  assign op_cp0    = (bus.inst[31:26] == 6'b010000);
  assign is_mtc0   = op_cp0 && (bus.inst[25:21] == 5'b00100) && (bus.inst[10:3] == 8'd0);
  assign is_mfc0   = op_cp0 && (bus.inst[25:21] == 5'b00000) && (bus.inst[10:3] == 8'd0);
  assign is_eret   = (bus.inst == 32'h4200_0018);
  assign addr      = {bus.inst[15:11], bus.inst[2:0]};
  assign wdata     = bus.reg_data_1;
  // A committing exception squashes whatever ID is trying to do to CP0 state.
  assign mtc0_fire = is_mtc0 && !bus.stall && !bus.exc_valid;
  assign eret_fire = is_eret && !bus.stall && !bus.exc_valid;
  assign mfc0_fire = is_mfc0 && !bus.stall;

  logic [7:0]      im_q, im_d;
  logic            exl_q, exl_d, ie_q, ie_d;
  logic [1:0]      ip_sw_q, ip_sw_d;
  logic [HW_W-1:0] ip_hw_q, ip_hw_d;
  logic            bd_q, bd_d;
  logic [4:0]      code_q, code_d;
  logic [31:0]     epc_q, epc_d, badv_q, badv_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d, eret_q, eret_d, irq_q, irq_d;
  logic [31:0]     status_val, cause_val, read_mux;

`ifdef CP0_TIMER_EN
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d, compare_q, compare_d;
  logic          ti_q, ti_d, tick;

  assign tick      = (presc_q == PRESC_MAX);
  assign cause_val = {bd_q, ti_q, 14'd0, ti_q, ip_hw_q, ip_sw_q, 1'b0, code_q, 2'b00};
`else
  assign cause_val = {bd_q, 1'b0, 14'd0, ip_hw_q, ip_sw_q, 1'b0, code_q, 2'b00};
`endif

  assign status_val = {STATUS_RESET[31:16], im_q, STATUS_RESET[7:2], exl_q, ie_q};

  always_comb begin
    read_mux = '0;
    case (addr)
      A_BADV:    read_mux = badv_q;
`ifdef CP0_TIMER_EN
      A_COUNT:   read_mux = count_q;
      A_COMPARE: read_mux = compare_q;
`endif
      A_STATUS:  read_mux = status_val;
      A_CAUSE:   read_mux = cause_val;
      A_EPC:     read_mux = epc_q;
      default:   read_mux = '0;
    endcase
  end

  always_comb begin
    im_d     = im_q;
    exl_d    = exl_q;
    ie_d     = ie_q;
    ip_sw_d  = ip_sw_q;
    bd_d     = bd_q;
    code_d   = code_q;
    epc_d    = epc_q;
    badv_d   = badv_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    eret_d   = 1'b0;
    ip_hw_d  = '0;
    for (int i = 0; i < NUM_HW_INT; i++) ip_hw_d[i] = bus.int_in[i];
    irq_d = ie_q && !exl_q && |(cause_val[15:8] & im_q);

    if (mfc0_fire) begin
      rdata_d  = read_mux;
      rvalid_d = 1'b1;
    end

    if (bus.exc_valid) begin
      code_d = bus.exc_code;
      // Nested exceptions keep the original return address.
      if (!exl_q) begin
        epc_d = bus.exc_epc;
        bd_d  = bus.exc_bd;
      end
      if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) badv_d = bus.exc_badvaddr;
      exl_d = 1'b1;
    end else begin
      if (mtc0_fire) begin
        case (addr)
          A_STATUS: begin
            im_d  = wdata[15:8];
            exl_d = wdata[1];
            ie_d  = wdata[0];
          end
          A_CAUSE: ip_sw_d = wdata[9:8];
          A_EPC:   epc_d   = wdata;
          default: ;
        endcase
      end
      if (eret_fire) begin
        exl_d  = 1'b0;
        eret_d = 1'b1;
      end
    end
  end

`ifdef CP0_TIMER_EN
  // A software write to Count replaces the increment, so it also cannot raise TI.
  always_comb begin
    presc_d   = tick ? '0 : presc_q + PW'(1);
    count_d   = tick ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q | (tick && (count_q + 32'd1 == compare_q));
    if (mtc0_fire && addr == A_COUNT) begin
      count_d = wdata;
      presc_d = '0;
      ti_d    = ti_q;
    end
    if (mtc0_fire && addr == A_COMPARE) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q     <= STATUS_RESET[15:8];
      exl_q    <= STATUS_RESET[1];
      ie_q     <= STATUS_RESET[0];
      ip_sw_q  <= '0;
      ip_hw_q  <= '0;
      bd_q     <= 1'b0;
      code_q   <= '0;
      epc_q    <= '0;
      badv_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      eret_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      im_q     <= im_d;
      exl_q    <= exl_d;
      ie_q     <= ie_d;
      ip_sw_q  <= ip_sw_d;
      ip_hw_q  <= ip_hw_d;
      bd_q     <= bd_d;
      code_q   <= code_d;
      epc_q    <= epc_d;
      badv_q   <= badv_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      eret_q   <= eret_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.cp0_read_data  = rdata_q;
  assign bus.cp0_read_valid = rvalid_q;
  assign bus.illegal        = !rst && op_cp0 && !(is_mtc0 || is_mfc0 || is_eret);
  assign bus.int_pending    = irq_q;
  assign bus.eret           = eret_q;
  assign bus.epc_out        = epc_q;
  assign bus.status_out     = status_val;
  assign bus.cause_out      = cause_val;

endmodule

// File: tb/tb_cp0_regfile_ctrl.sv
// Directed and randomized bench for cp0_regfile_ctrl; timer checks run only when CP0_TIMER_EN is defined.
module tb_cp0_regfile_ctrl;
`ifdef CP0_TIMER_EN
  localparam int NHW = 5;
`else
  localparam int NHW = 6;
`endif
  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ERET = 32'h4200_0018;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cp0_regfile_ctrl_if #(.NUM_HW_INT(NHW)) bus ();

  cp0_regfile_ctrl #(
    .NUM_HW_INT(NHW),
    .COUNT_DIV(2),
    .STATUS_RESET(32'h0040_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [31:0] mtc0(input int rd);
    return {6'b010000, 5'b00100, 5'd1, 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] mfc0(input int rd);
    return {6'b010000, 5'b00000, 5'd2, 5'(rd), 11'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] data, input logic stall);
    bus.inst       = inst;
    bus.reg_data_1 = data;
    bus.stall      = stall;
  endtask

  task automatic applyException(input logic valid, input logic [4:0] code, input logic [31:0] epc,
                                input logic bd, input logic [31:0] badv);
    bus.exc_valid    = valid;
    bus.exc_code     = code;
    bus.exc_epc      = epc;
    bus.exc_bd       = bd;
    bus.exc_badvaddr = badv;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference model state for the randomized register traffic
  logic [31:0] mStatus, mCause, mEpc, mBadv;

  function automatic logic [31:0] modelRead(input int rd);
    case (rd)
      8:       return mBadv;
      12:      return mStatus;
      13:      return mCause;
      14:      return mEpc;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
`ifdef CP0_TIMER_EN
    int addrs[6] = '{8, 12, 13, 14, 15, 3};
`else
    int addrs[8] = '{8, 12, 13, 14, 15, 3, 9, 11};
`endif
    rst = 1'b1;
    applyStimulus(NOP, 32'd0, 1'b0);
    applyException(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    bus.int_in = '0;
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_status", bus.status_out, 32'h0040_0000);
    checkOutput("rst_cause", bus.cause_out, 32'd0);
    checkOutput("rst_epc", bus.epc_out, 32'd0);
    checkOutput("rst_irq", 32'(bus.int_pending), 32'd0);
    checkOutput("rst_rvalid", 32'(bus.cp0_read_valid), 32'd0);
    checkOutput("rst_rdata", bus.cp0_read_data, 32'd0);
    checkOutput("rst_eret", 32'(bus.eret), 32'd0);
    checkOutput("rst_illegal", 32'(bus.illegal), 32'd0);
    rst = 1'b0;

    applyStimulus(mtc0(12), 32'hFFFF_FFFF, 1'b0);
    tick();
    checkOutput("mtc0_status", bus.status_out, 32'h0040_FF03);
    checkOutput("mtc0_no_rvalid", 32'(bus.cp0_read_valid), 32'd0);
    applyStimulus(mfc0(12), 32'd0, 1'b0);
    tick();
    checkOutput("mfc0_status", bus.cp0_read_data, 32'h0040_FF03);
    checkOutput("mfc0_rvalid", 32'(bus.cp0_read_valid), 32'd1);
    applyStimulus(NOP, 32'd0, 1'b0);
    tick();
    checkOutput("rvalid_one_cycle", 32'(bus.cp0_read_valid), 32'd0);
    checkOutput("irq_exl_masked", 32'(bus.int_pending), 32'd0);
    applyStimulus(mtc0(12), 32'd0, 1'b0);
    tick();
    checkOutput("status_clear", bus.status_out, 32'h0040_0000);

    $display("[TB] exception entry and return");
    applyStimulus(NOP, 32'd0, 1'b0);
    applyException(1'b1, 5'd12, 32'hBFC0_0100, 1'b1, 32'h0000_5555);
    tick();
    checkOutput("exc1_epc", bus.epc_out, 32'hBFC0_0100);
    checkOutput("exc1_cause", bus.cause_out, 32'h8000_0030);
    checkOutput("exc1_status", bus.status_out, 32'h0040_0002);
    applyException(1'b1, 5'd4, 32'h0000_1234, 1'b0, 32'hDEAD_BEEF);
    tick();
    checkOutput("exc2_epc", bus.epc_out, 32'hBFC0_0100);
    checkOutput("exc2_cause", bus.cause_out, 32'h8000_0010);
    applyException(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    applyStimulus(ERET, 32'd0, 1'b0);
    tick();
    checkOutput("eret_pulse", 32'(bus.eret), 32'd1);
    checkOutput("eret_status", bus.status_out, 32'h0040_0000);
    checkOutput("eret_epc", bus.epc_out, 32'hBFC0_0100);
    applyStimulus(NOP, 32'd0, 1'b0);
    tick();
    checkOutput("eret_one_cycle", 32'(bus.eret), 32'd0);

    applyException(1'b1, 5'd0, 32'h0000_0100, 1'b0, 32'd0);
    tick();
    checkOutput("exc3_epc", bus.epc_out, 32'h0000_0100);
    checkOutput("exc3_cause", bus.cause_out, 32'h0000_0000);
    applyStimulus(ERET, 32'd0, 1'b0);
    applyException(1'b1, 5'd8, 32'h0000_0200, 1'b1, 32'd0);
    tick();
    checkOutput("exc_eret_eret", 32'(bus.eret), 32'd0);
    checkOutput("exc_eret_status", bus.status_out, 32'h0040_0002);
    checkOutput("exc_eret_epc", bus.epc_out, 32'h0000_0100);
    checkOutput("exc_eret_cause", bus.cause_out, 32'h0000_0020);
    applyException(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

    $display("[TB] illegal encodings, reads and stall");
    applyStimulus(32'h4080_4009, 32'hFFFF_FFFF, 1'b0);
    #1;
    checkOutput("illegal_flag", 32'(bus.illegal), 32'd1);
    tick();
    applyStimulus(mtc0(14) | 32'h0000_0008, 32'hFFFF_FFFF, 1'b0);
    #1;
    checkOutput("illegal_epc_flag", 32'(bus.illegal), 32'd1);
    tick();
    checkOutput("illegal_epc", bus.epc_out, 32'h0000_0100);
    checkOutput("illegal_status", bus.status_out, 32'h0040_0002);
    applyStimulus(mfc0(15), 32'd0, 1'b0);
    #1;
    checkOutput("legal_flag", 32'(bus.illegal), 32'd0);
    tick();
    checkOutput("mfc0_unimpl", bus.cp0_read_data, 32'd0);
    checkOutput("mfc0_unimpl_v", 32'(bus.cp0_read_valid), 32'd1);
    applyStimulus(mfc0(8), 32'd0, 1'b0);
    tick();
    checkOutput("mfc0_badv", bus.cp0_read_data, 32'hDEAD_BEEF);
    applyStimulus(mfc0(12), 32'd0, 1'b1);
    tick();
    checkOutput("stall_rvalid", 32'(bus.cp0_read_valid), 32'd0);
    checkOutput("stall_rdata", bus.cp0_read_data, 32'hDEAD_BEEF);
    applyStimulus(mtc0(14), 32'hAAAA_5555, 1'b1);
    tick();
    checkOutput("stall_epc", bus.epc_out, 32'h0000_0100);
    applyStimulus(mtc0(14), 32'hAAAA_5555, 1'b0);
    tick();
    checkOutput("write_epc", bus.epc_out, 32'hAAAA_5555);
    applyStimulus(mfc0(14), 32'd0, 1'b0);
    tick();
    checkOutput("raw_epc", bus.cp0_read_data, 32'hAAAA_5555);

    $display("[TB] hardware interrupt");
    applyStimulus(mtc0(12), 32'h0000_0401, 1'b0);
    bus.int_in = NHW'(1);
    tick();
    checkOutput("irq_status", bus.status_out, 32'h0040_0401);
    checkOutput("irq_cause", bus.cause_out, 32'h0000_0420);
    checkOutput("irq_lag", 32'(bus.int_pending), 32'd0);
    applyStimulus(NOP, 32'd0, 1'b0);
    tick();
    checkOutput("irq_set", 32'(bus.int_pending), 32'd1);
    bus.int_in = '0;
    tick();
    checkOutput("irq_cause_clr", bus.cause_out, 32'h0000_0020);
    tick();
    checkOutput("irq_clr", 32'(bus.int_pending), 32'd0);

    $display("[TB] randomized register traffic");
    mStatus = 32'h0040_0401;
    mCause  = 32'h0000_0020;
    mEpc    = 32'hAAAA_5555;
    mBadv   = 32'hDEAD_BEEF;
    for (int n = 0; n < 30; n++) begin
      int rd;
      logic [31:0] d;
      rd = addrs[$urandom_range(0, $size(addrs) - 1)];
      d  = $urandom;
      applyStimulus(mtc0(rd), d, 1'b0);
      tick();
      case (rd)
        12: mStatus = (mStatus & ~32'h0000_FF03) | (d & 32'h0000_FF03);
        13: mCause  = (mCause & ~32'h0000_0300) | (d & 32'h0000_0300);
        14: mEpc    = d;
        default: ;
      endcase
      checkOutput("rand_status", bus.status_out, mStatus);
      applyStimulus(mfc0(rd), 32'd0, 1'b0);
      tick();
      checkOutput($sformatf("rand_read_%0d", rd), bus.cp0_read_data, modelRead(rd));
    end

`ifdef CP0_TIMER_EN
    $display("[TB] count/compare timer");
    applyStimulus(mtc0(11), 32'd5, 1'b0);
    tick();
    applyStimulus(mtc0(9), 32'd0, 1'b0);
    tick();
    applyStimulus(mtc0(12), 32'h0000_8001, 1'b0);
    tick();
    applyStimulus(NOP, 32'd0, 1'b0);
    repeat (8) tick();
    checkOutput("ti_early", 32'(bus.cause_out[30]), 32'd0);
    tick();
    checkOutput("ti_set", 32'(bus.cause_out[30]), 32'd1);
    checkOutput("ip7_set", 32'(bus.cause_out[15]), 32'd1);
    checkOutput("ti_irq_lag", 32'(bus.int_pending), 32'd0);
    tick();
    checkOutput("ti_irq", 32'(bus.int_pending), 32'd1);
    applyStimulus(mtc0(11), 32'd5, 1'b0);
    tick();
    checkOutput("ti_clear", 32'(bus.cause_out[30]), 32'd0);
    applyStimulus(NOP, 32'd0, 1'b0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_regfile_ctrl.md
Name: cp0_regfile_ctrl

Overview:
- Successor to the ID-stage CP0 decoder.
- Decodes MTC0/MFC0/ERET and owns the architectural CP0 registers: BadVAddr, Count, Compare, Status, Cause, EPC.
- Sits between ID (decode, register write) and MEM (exception commit).
- Adds a parametrised hardware-interrupt count, a divided Count/Compare timer, exception entry/return sequencing, and registered read data.

Parameters:
- NUM_HW_INT, 6, number of hardware interrupt lines. Range 1..5 with the timer compiled in, 1..6 without. Lines map to Cause.IP[2+i].
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles. Must be ≥1.
- STATUS_RESET, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high, sampled on rising clk.
- stall  in  1  holds ID. Suppresses MTC0 commit and the MFC0 read strobe.
- inst  in  32  ID-stage instruction word.
- reg_data_1  in  32  rt operand for MTC0.
- int_in  in  NUM_HW_INT  level hardware interrupts.
- exc_valid  in  1  exception commit pulse from MEM.
- exc_code  in  5  ExcCode to record.
- exc_epc  in  32  faulting PC.
- exc_bd  in  1  faulting instruction is in a delay slot.
- exc_badvaddr  in  32  bad address. Recorded only when exc_code is 4 or 5.
- cp0_read_data  out  32  MFC0 result, registered.
- cp0_read_valid  out  1  one-cycle strobe qualifying cp0_read_data.
- illegal  out  1  combinational: OP_CP0 with malformed encoding (inst[10:3]≠0 on MTC0/MFC0, or unknown rs).
- int_pending  out  1  registered interrupt request to the pipeline.
- eret  out  1  one-cycle pulse on ERET commit.
- epc_out  out  32  current EPC, continuous.
- status_out  out  32  current Status.
- cause_out  out  32  current Cause.

Behaviour:
- Address is {rd, inst[2:0]}. Implemented addresses: (8,0) BadVAddr, (9,0) Count, (11,0) Compare, (12,0) Status, (13,0) Cause, (14,0) EPC. All others read 0; writes to them are ignored.
- Decode:
  - OP_CP0 with rs=00100 → MTC0.
  - OP_CP0 with rs=00000 → MFC0.
  - inst==32'h4200_0018 → ERET.
  - Any other OP_CP0 encoding → illegal=1, no state change.
- MTC0: commits on the rising edge ending the decode cycle when stall=0. Writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8] only.
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr: read-only.
- MFC0: at the edge, cp0_read_data ← pre-edge register value and cp0_read_valid=1 for one cycle. With stall=1, cp0_read_valid=0 and cp0_read_data holds.
- MFC0 directly after MTC0 to the same register returns the new value (1-cycle write latency, 1-cycle read latency).
- Count:
  - Prescaler counts 0..COUNT_DIV-1; Count+1 on wrap, modulo 2^32.
  - MTC0 Count loads the value and clears the prescaler.
- Timer interrupt:
  - Count==Compare after an increment sets Cause.TI[30] and IP[7].
  - MTC0 Compare clears TI and IP[7].
- Cause.IP[2+i] ← int_in[i] every cycle (registered).
- int_pending ← Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM) (registered, 1-cycle lag).
- Exception entry (exc_valid=1):
  - Cause.ExcCode ← exc_code.
  - If EXL=0: EPC ← exc_epc; Cause.BD ← exc_bd. If EXL=1, EPC and BD are unchanged.
  - EXL ← 1.
- ERET (not stalled): EXL ← 0 and eret pulses 1 for one cycle. epc_out is already valid during that cycle.
- Simultaneous events:
  - exc_valid with MTC0 or ERET in the same cycle: the exception wins and the MTC0/ERET is discarded.
  - MTC0 Count with an increment in the same cycle: the written value wins.
  - MTC0 Compare with a match in the same cycle: TI ends cleared.
- Reset:
  - Status=STATUS_RESET; Cause, Count, Compare, EPC, BadVAddr = 0; prescaler = 0.
  - All outputs 0 except status_out=STATUS_RESET.
  - Reset mid-exception discards the commit.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count/Compare registers, prescaler and TI/IP[7] logic present as described.
- Undefined:
  - Addresses (9,0) and (11,0) behave as unimplemented (read 0, writes ignored).
  - TI and IP[7] are constantly 0.
  - NUM_HW_INT may be 6, driving IP[7] from int_in[5].

Test Plan:
- Reset → status_out=32'h0040_0000, cause_out=0, epc_out=0, int_pending=0, cp0_read_valid=0.
- MTC0 Status ← 32'hFFFF_FFFF, then MFC0 Status next cycle → cp0_read_data=32'h0040_FF03, cp0_read_valid=1 for exactly one cycle.
- CP0_TIMER_EN, COUNT_DIV=2:
  - MTC0 Compare=5, MTC0 Count=0, IE=1, IM7=1 → TI set 10 cycles after the Count write; int_pending=1 one cycle later.
  - MTC0 Compare=5 again → TI=0.
- EXL=0, exc_valid with exc_code=12, exc_epc=32'hBFC0_0100, exc_bd=1 → EPC=32'hBFC0_0100, Cause[31]=1, Cause[6:2]=12, EXL=1.
- Second exception with exc_epc=32'h1234 while EXL=1 → EPC unchanged.
- ERET → eret=1 for one cycle, EXL=0.
- ERET and exc_valid in the same cycle → EXL stays 1, eret=0.
- inst=32'h4080_4009 (inst[10:3]≠0) → illegal=1, no register change.
- MFC0 of (15,0) → read 0.
- stall=1 on MTC0 EPC → EPC unchanged.
